// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: one write port and one registered read port.
// No reset on the array or the read register, so it can map onto block or distributed RAM.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap-bit pointers, registered status flags,
// occupancy count and one-cycle overflow/underflow pulses.
module sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int POINTER      = 4,
    parameter int AFULL_LEVEL  = (1 << POINTER) - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid,
    output logic               wr_full,
    output logic               rd_empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [POINTER:0]   fill_count,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 1 << POINTER;
    localparam int PW    = POINTER + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_LEVEL);

    if (POINTER < 1) begin : g_bad_pointer
        $error("sync_fifo: POINTER must be at least 1");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("sync_fifo: AFULL_LEVEL out of range 1..DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo: AEMPTY_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_afull;
    logic             r_aempty;
    logic             r_valid;
    logic             r_ovf;
    logic             r_unf;
    logic             r_seen;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [PW-1:0]    w_count_nxt;
    logic             w_full_nxt;
    logic             w_empty_nxt;
    logic [WIDTH-1:0] w_ram_q;

    assign w_wr_acc     = wr_en & ~r_full;
    assign w_rd_acc     = rd_en & ~r_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_full_nxt   = (w_wr_ptr_nxt[PW-2:0] == w_rd_ptr_nxt[PW-2:0]) &&
                          (w_wr_ptr_nxt[PW-1] != w_rd_ptr_nxt[PW-1]);
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (POINTER)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[PW-2:0]),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[PW-2:0]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_seen   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
            r_afull  <= (w_count_nxt >= AF_LVL);
            r_aempty <= (w_count_nxt <= AE_LVL);
            r_valid  <= w_rd_acc;
            r_ovf    <= wr_en & r_full;
            r_unf    <= rd_en & r_empty;
            if (w_rd_acc) begin
                r_seen <= 1'b1;
            end
        end
    end

    // The RAM read register has no reset; until the first post-reset read lands
    // the output is forced to zero, afterwards the RAM register holds between reads.
    assign data_out     = r_seen ? w_ram_q : '0;
    assign data_valid   = r_valid;
    assign wr_full      = r_full;
    assign rd_empty     = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign fill_count   = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_sync_fifo;

    localparam int WIDTH  = 8;
    localparam int PTR    = 4;
    localparam int DEPTH  = 1 << PTR;
    localparam int AFULL  = DEPTH - 2;
    localparam int AEMPTY = 2;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             wr_full;
    logic             rd_empty;
    logic             almost_full;
    logic             almost_empty;
    logic [PTR:0]     fill_count;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_unf;

    sync_fifo #(
        .WIDTH        (WIDTH),
        .POINTER      (PTR),
        .AFULL_LEVEL  (AFULL),
        .AEMPTY_LEVEL (AEMPTY)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .wr_full      (wr_full),
        .rd_empty     (rd_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill_count   (fill_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compares every output against the model's view of the FIFO.
    task automatic check_all(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".fill_count"},   32'(fill_count),   32'(sz));
        check({tag, ".wr_full"},      32'(wr_full),      32'(sz == DEPTH));
        check({tag, ".rd_empty"},     32'(rd_empty),     32'(sz == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AFULL));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AEMPTY));
        check({tag, ".data_valid"},   32'(data_valid),   32'(exp_valid));
        check({tag, ".data_out"},     32'(data_out),     32'(exp_dout));
        check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(exp_unf));
    endtask

    // One clock of traffic: drive, advance the model on the edge, check after the edge.
    task automatic step(input string tag, input logic wr, input logic rd, input logic [WIDTH-1:0] din);
        bit was_full;
        bit was_empty;
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        exp_ovf   = wr && was_full;
        exp_unf   = rd && was_empty;
        exp_valid = rd && !was_empty;
        if (rd && !was_empty) exp_dout = exp_q.pop_front();
        if (wr && !was_full) exp_q.push_back(din);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        step("idle", 1'b0, 1'b0, 8'h00);
        step("idle2", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));
        step("overflow", 1'b1, 1'b0, 8'hAA);
        step("after_ovf", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
        step("underflow", 1'b0, 1'b1, 8'h00);
        step("after_unf", 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        while (exp_q.size() < DEPTH) step("refill", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
        step("full_wr_rd", 1'b1, 1'b1, 8'h55);
        while (exp_q.size() > 0) step("empty_out", 1'b0, 1'b1, 8'h00);
        step("empty_wr_rd", 1'b1, 1'b1, 8'h77);
        step("empty_wr_rd_read", 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 8'($urandom_range(0, 255)));
        end
        while (exp_q.size() > 0) step("random_drain", 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 5; i++) step("burst", 1'b1, 1'b0, 8'(8'h30 + i));
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(posedge clk);
        #1;
        check_all("mid_reset_held");
        reset_n = 1'b1;
        step("post_reset_wr", 1'b1, 1'b0, 8'h99);
        step("post_reset_rd", 1'b0, 1'b1, 8'h00);
        step("post_reset_idle", 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
